// File: rtl/register_file_pkg.sv
// ---------------------------------------------------------------------------
// register_file_pkg
// Shared types and default sizing for the general-purpose / pointer register
// bank.
//   rf_op_t                : in-place operation applied to the target entry
//   RF_DEFAULT_DATA_WIDTH  : default word width (11 bits)
//   RF_DEFAULT_NUM_REGS    : default entry count (8)
// ---------------------------------------------------------------------------
package register_file_pkg;

  typedef enum logic [1:0] {
    RF_LOAD = 2'b00,
    RF_INC  = 2'b01,
    RF_DEC  = 2'b10,
    RF_CLR  = 2'b11
  } rf_op_t;

  localparam int RF_DEFAULT_DATA_WIDTH = 11;
  localparam int RF_DEFAULT_NUM_REGS   = 8;

endpackage

// File: rtl/register_file_next_value.sv
// ---------------------------------------------------------------------------
// rf_next_value
// Combinational next-value generator for one register entry. The same result
// feeds both the array write and the read-port bypass, so the two can never
// disagree.
// Ports:
//   cur        in  DATA_WIDTH  current entry value
//   rf_wr_data in  DATA_WIDTH  load data (used by RF_LOAD only)
//   rf_op      in  rf_op_t     operation
//   next       out DATA_WIDTH  value the entry takes if the write commits
//   wrap       out 1           INC of all-ones or DEC of zero
// ---------------------------------------------------------------------------
module rf_next_value
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH = RF_DEFAULT_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] cur,
  input  logic [DATA_WIDTH-1:0] rf_wr_data,
  input  rf_op_t                rf_op,
  output logic [DATA_WIDTH-1:0] next,
  output logic                  wrap
);

  localparam logic [DATA_WIDTH-1:0] ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  always_comb begin
    next = cur;
    wrap = 1'b0;
    case (rf_op)
      RF_LOAD: next = rf_wr_data;
      RF_INC: begin
        next = cur + ONE;
        wrap = &cur;
      end
      RF_DEC: begin
        next = cur - ONE;
        wrap = ~|cur;
      end
      RF_CLR:  next = '0;
      default: next = cur;
    endcase
  end

endmodule

// File: rtl/register_file.sv
// ---------------------------------------------------------------------------
// register_file
// NUM_REGS x DATA_WIDTH register bank with one write/modify port
// (LOAD/INC/DEC/CLR), two combinational read ports with optional same-cycle
// bypass, and a registered wrap pulse for INC/DEC overflow.
// Ports:
//   clock         in  1           rising-edge clock
//   rf_reset_n    in  1           asynchronous active-low reset
//   rf_wr         in  1           write/modify enable
//   rf_op         in  2           operation (rf_op_t encoding)
//   rf_wr_addr    in  ADDR_WIDTH  target entry
//   rf_wr_data    in  DATA_WIDTH  load data
//   rf_rd_addr_a  in  ADDR_WIDTH  read port A address
//   rf_rd_addr_b  in  ADDR_WIDTH  read port B address
//   rf_rd_data_a  out DATA_WIDTH  read port A data
//   rf_rd_data_b  out DATA_WIDTH  read port B data
//   rf_wrap       out 1           one-cycle pulse after a committed wrap
// ---------------------------------------------------------------------------
module register_file
  import register_file_pkg::*;
#(
  parameter int                   DATA_WIDTH  = RF_DEFAULT_DATA_WIDTH,
  parameter int                   NUM_REGS    = RF_DEFAULT_NUM_REGS,
  parameter int                   ADDR_WIDTH  = $clog2(NUM_REGS),
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  parameter int                   ZERO_REG    = 1,
  parameter int                   BYPASS      = 1
) (
  input  logic                  clock,
  input  logic                  rf_reset_n,
  input  logic                  rf_wr,
  input  logic [1:0]            rf_op,
  input  logic [ADDR_WIDTH-1:0] rf_wr_addr,
  input  logic [DATA_WIDTH-1:0] rf_wr_data,
  input  logic [ADDR_WIDTH-1:0] rf_rd_addr_a,
  input  logic [ADDR_WIDTH-1:0] rf_rd_addr_b,
  output logic [DATA_WIDTH-1:0] rf_rd_data_a,
  output logic [DATA_WIDTH-1:0] rf_rd_data_b,
  output logic                  rf_wrap
);

  // One extra bit so NUM_REGS itself is representable when it is a power of two.
  localparam logic [ADDR_WIDTH:0] NUM_REGS_W = NUM_REGS[ADDR_WIDTH:0];

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [DATA_WIDTH-1:0] cur_val;
  logic [DATA_WIDTH-1:0] nv_next;
  logic                  nv_wrap;
  logic                  wr_eff;

  function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] a);
    return ({1'b0, a} < NUM_REGS_W);
  endfunction

  function automatic logic addr_is_zero_reg(input logic [ADDR_WIDTH-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Suppressed writes (hard-wired zero entry, out-of-range address) are
  // treated as if rf_wr were low: no state change, no wrap, no bypass.
  assign wr_eff  = rf_wr && addr_in_range(rf_wr_addr) && !addr_is_zero_reg(rf_wr_addr);
  assign cur_val = addr_in_range(rf_wr_addr) ? regs[rf_wr_addr] : '0;

  rf_next_value #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_next_value (
    .cur        (cur_val),
    .rf_wr_data (rf_wr_data),
    .rf_op      (rf_op_t'(rf_op)),
    .next       (nv_next),
    .wrap       (nv_wrap)
  );

  always_ff @(posedge clock or negedge rf_reset_n) begin
    if (!rf_reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= RESET_VALUE;
      end
      rf_wrap <= 1'b0;
    end else begin
      rf_wrap <= wr_eff && nv_wrap;
      if (wr_eff) begin
        regs[rf_wr_addr] <= nv_next;
      end
    end
  end

  // Both read ports share identical logic; index 0 is A, index 1 is B.
  logic [ADDR_WIDTH-1:0] rd_addr [2];
  logic [DATA_WIDTH-1:0] rd_data [2];

  assign rd_addr[0]   = rf_rd_addr_a;
  assign rd_addr[1]   = rf_rd_addr_b;
  assign rf_rd_data_a = rd_data[0];
  assign rf_rd_data_b = rd_data[1];

  for (genvar p = 0; p < 2; p++) begin : g_rd_port
    always_comb begin
      rd_data[p] = '0;
      if ((BYPASS != 0) && wr_eff && (rd_addr[p] == rf_wr_addr)) begin
        rd_data[p] = nv_next;
      end else if (addr_in_range(rd_addr[p]) && !addr_is_zero_reg(rd_addr[p])) begin
        rd_data[p] = regs[rd_addr[p]];
      end
    end
  end

endmodule

// File: tb/tb_register_file.sv
module tb_register_file;

  logic        clock;
  logic        rf_reset_n;
  logic        rf_wr;
  logic [1:0]  rf_op;
  logic [2:0]  rf_wr_addr;
  logic [10:0] rf_wr_data;
  logic [2:0]  rf_rd_addr_a;
  logic [2:0]  rf_rd_addr_b;

  logic [10:0] rd_a,    rd_b;
  logic [10:0] rd6_a,   rd6_b;
  logic [10:0] rdnb_a,  rdnb_b;
  logic        wrap, wrap6, wrapnb;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_INC  = 2'b01;
  localparam logic [1:0] OP_DEC  = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;
  localparam logic [10:0] RV     = 11'h155;

  // Main configuration: 8 entries, zero register, bypass on.
  register_file #(
    .DATA_WIDTH (11), .NUM_REGS (8), .RESET_VALUE (RV), .ZERO_REG (1), .BYPASS (1)
  ) dut (
    .clock (clock), .rf_reset_n (rf_reset_n), .rf_wr (rf_wr), .rf_op (rf_op),
    .rf_wr_addr (rf_wr_addr), .rf_wr_data (rf_wr_data),
    .rf_rd_addr_a (rf_rd_addr_a), .rf_rd_addr_b (rf_rd_addr_b),
    .rf_rd_data_a (rd_a), .rf_rd_data_b (rd_b), .rf_wrap (wrap)
  );

  // Non-power-of-two entry count, same inputs.
  register_file #(
    .DATA_WIDTH (11), .NUM_REGS (6), .RESET_VALUE (RV), .ZERO_REG (1), .BYPASS (1)
  ) dut6 (
    .clock (clock), .rf_reset_n (rf_reset_n), .rf_wr (rf_wr), .rf_op (rf_op),
    .rf_wr_addr (rf_wr_addr), .rf_wr_data (rf_wr_data),
    .rf_rd_addr_a (rf_rd_addr_a), .rf_rd_addr_b (rf_rd_addr_b),
    .rf_rd_data_a (rd6_a), .rf_rd_data_b (rd6_b), .rf_wrap (wrap6)
  );

  // Bypass disabled, same inputs.
  register_file #(
    .DATA_WIDTH (11), .NUM_REGS (8), .RESET_VALUE (RV), .ZERO_REG (1), .BYPASS (0)
  ) dutnb (
    .clock (clock), .rf_reset_n (rf_reset_n), .rf_wr (rf_wr), .rf_op (rf_op),
    .rf_wr_addr (rf_wr_addr), .rf_wr_data (rf_wr_data),
    .rf_rd_addr_a (rf_rd_addr_a), .rf_rd_addr_b (rf_rd_addr_b),
    .rf_rd_data_a (rdnb_a), .rf_rd_data_b (rdnb_b), .rf_wrap (wrapnb)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Stimulus helper: one committed write, returns 1 time unit after the edge.
  task automatic drive_write(input logic [1:0] op, input logic [2:0] addr,
                             input logic [10:0] data);
    @(negedge clock);
    rf_wr      = 1'b1;
    rf_op      = op;
    rf_wr_addr = addr;
    rf_wr_data = data;
    @(posedge clock);
    #1;
    rf_wr = 1'b0;
  endtask

  task automatic test_reset;
    logic [10:0] exp;
    rf_reset_n = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    rf_reset_n = 1'b1;
    @(posedge clock);
    #1;
    checks++;
    if (wrap !== 1'b0) begin
      errors++;
      $display("FAIL reset_wrap got %b want 0", wrap);
    end
    for (int a = 0; a < 8; a++) begin
      rf_rd_addr_a = 3'(a);
      #1;
      exp = (a == 0) ? 11'h000 : RV;
      checks++;
      if (rd_a !== exp) begin
        errors++;
        $display("FAIL reset_entry%0d got %h want %h", a, rd_a, exp);
      end
      exp = (a == 0 || a > 5) ? 11'h000 : RV;
      checks++;
      if (rd6_a !== exp) begin
        errors++;
        $display("FAIL reset6_entry%0d got %h want %h", a, rd6_a, exp);
      end
    end
  endtask

  task automatic test_load;
    drive_write(OP_LOAD, 3'd3, 11'h2A5);
    rf_rd_addr_a = 3'd3;
    rf_rd_addr_b = 3'd3;
    #1;
    checks++;
    if (rd_a !== 11'h2A5) begin
      errors++;
      $display("FAIL load_port_a got %h want 2a5", rd_a);
    end
    checks++;
    if (rd_b !== 11'h2A5) begin
      errors++;
      $display("FAIL load_port_b got %h want 2a5", rd_b);
    end
  endtask

  task automatic test_wrap;
    drive_write(OP_LOAD, 3'd5, 11'h7FF);
    checks++;
    if (wrap !== 1'b0) begin
      errors++;
      $display("FAIL load_no_wrap got %b want 0", wrap);
    end
    drive_write(OP_INC, 3'd5, 11'h000);
    checks++;
    if (wrap !== 1'b1) begin
      errors++;
      $display("FAIL inc_wrap got %b want 1", wrap);
    end
    rf_rd_addr_a = 3'd5;
    #1;
    checks++;
    if (rd_a !== 11'h000) begin
      errors++;
      $display("FAIL inc_value got %h want 000", rd_a);
    end
    @(posedge clock);
    #1;
    checks++;
    if (wrap !== 1'b0) begin
      errors++;
      $display("FAIL inc_wrap_single got %b want 0", wrap);
    end
    drive_write(OP_DEC, 3'd5, 11'h000);
    checks++;
    if (wrap !== 1'b1) begin
      errors++;
      $display("FAIL dec_wrap got %b want 1", wrap);
    end
    #1;
    checks++;
    if (rd_a !== 11'h7FF) begin
      errors++;
      $display("FAIL dec_value got %h want 7ff", rd_a);
    end
    @(posedge clock);
    #1;
    checks++;
    if (wrap !== 1'b0) begin
      errors++;
      $display("FAIL dec_wrap_single got %b want 0", wrap);
    end
    // Non-wrapping INC must not pulse.
    drive_write(OP_INC, 3'd3, 11'h000);
    checks++;
    if (wrap !== 1'b0) begin
      errors++;
      $display("FAIL inc_nowrap got %b want 0", wrap);
    end
    drive_write(OP_DEC, 3'd3, 11'h000);
  endtask

  task automatic test_zero_oor;
    // DEC of entry 0 would wrap if it were writable.
    drive_write(OP_DEC, 3'd0, 11'h000);
    checks++;
    if (wrap !== 1'b0) begin
      errors++;
      $display("FAIL zero_dec_wrap got %b want 0", wrap);
    end
    drive_write(OP_LOAD, 3'd0, 11'h123);
    rf_rd_addr_a = 3'd0;
    #1;
    checks++;
    if (rd_a !== 11'h000) begin
      errors++;
      $display("FAIL zero_reg_read got %h want 000", rd_a);
    end
    // Address 7 is out of range for dut6 but valid for dut.
    @(negedge clock);
    rf_wr        = 1'b1;
    rf_op        = OP_LOAD;
    rf_wr_addr   = 3'd7;
    rf_wr_data   = 11'h3AB;
    rf_rd_addr_a = 3'd7;
    #1;
    checks++;
    if (rd6_a !== 11'h000) begin
      errors++;
      $display("FAIL oor_no_bypass got %h want 000", rd6_a);
    end
    checks++;
    if (rd_a !== 11'h3AB) begin
      errors++;
      $display("FAIL inrange_bypass got %h want 3ab", rd_a);
    end
    @(posedge clock);
    #1;
    rf_wr = 1'b0;
    checks++;
    if (rd6_a !== 11'h000) begin
      errors++;
      $display("FAIL oor_read got %h want 000", rd6_a);
    end
    checks++;
    if (wrap6 !== 1'b0) begin
      errors++;
      $display("FAIL oor_wrap got %b want 0", wrap6);
    end
    for (int a = 1; a < 6; a++) begin
      rf_rd_addr_a = 3'(a);
      #1;
      checks++;
      if (rd6_a !== ((a == 3) ? 11'h2A5 : (a == 5) ? 11'h7FF : RV)) begin
        errors++;
        $display("FAIL oor_entry%0d got %h", a, rd6_a);
      end
    end
  endtask

  task automatic test_bypass;
    drive_write(OP_LOAD, 3'd2, 11'h010);
    @(negedge clock);
    rf_wr        = 1'b1;
    rf_op        = OP_INC;
    rf_wr_addr   = 3'd2;
    rf_rd_addr_a = 3'd2;
    rf_rd_addr_b = 3'd2;
    #1;
    checks++;
    if (rd_a !== 11'h011 || rd_b !== 11'h011) begin
      errors++;
      $display("FAIL bypass_ab got %h %h want 011 011", rd_a, rd_b);
    end
    checks++;
    if (rdnb_a !== 11'h010 || rdnb_b !== 11'h010) begin
      errors++;
      $display("FAIL nobypass_ab got %h %h want 010 010", rdnb_a, rdnb_b);
    end
    @(posedge clock);
    #1;
    rf_wr = 1'b0;
    #1;
    checks++;
    if (rd_a !== 11'h011 || rdnb_a !== 11'h011) begin
      errors++;
      $display("FAIL bypass_commit got %h %h want 011 011", rd_a, rdnb_a);
    end
  endtask

  task automatic test_clr_hold;
    logic [10:0] exp [8];
    exp = '{11'h000, RV, 11'h011, 11'h2A5, 11'h000, 11'h7FF, RV, 11'h3AB};
    drive_write(OP_LOAD, 3'd4, 11'h3C3);
    rf_rd_addr_a = 3'd4;
    #1;
    checks++;
    if (rd_a !== 11'h3C3) begin
      errors++;
      $display("FAIL clr_preload got %h want 3c3", rd_a);
    end
    drive_write(OP_CLR, 3'd4, 11'h5A5);
    #1;
    checks++;
    if (rd_a !== 11'h000) begin
      errors++;
      $display("FAIL clr_value got %h want 000", rd_a);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      rf_wr      = 1'b0;
      rf_op      = 2'($urandom_range(0, 3));
      rf_wr_addr = 3'($urandom_range(0, 7));
      rf_wr_data = 11'($urandom);
      @(posedge clock);
      #1;
      checks++;
      if (wrap !== 1'b0) begin
        errors++;
        $display("FAIL hold_wrap cycle%0d got %b want 0", c, wrap);
      end
    end
    for (int a = 0; a < 8; a++) begin
      rf_rd_addr_b = 3'(a);
      #1;
      checks++;
      if (rd_b !== exp[a]) begin
        errors++;
        $display("FAIL hold_entry%0d got %h want %h", a, rd_b, exp[a]);
      end
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clock);
    rf_wr      = 1'b1;
    rf_op      = OP_LOAD;
    rf_wr_addr = 3'd1;
    rf_wr_data = 11'h0FF;
    #2;
    rf_reset_n = 1'b0;
    #1;
    rf_wr = 1'b0;
    // Still before the next rising edge: reset must already have taken effect.
    rf_rd_addr_a = 3'd4;
    rf_rd_addr_b = 3'd2;
    #1;
    checks++;
    if (rd_a !== RV || rd_b !== RV) begin
      errors++;
      $display("FAIL async_reset got %h %h want %h %h", rd_a, rd_b, RV, RV);
    end
    checks++;
    if (wrap !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_wrap got %b want 0", wrap);
    end
    @(negedge clock);
    rf_reset_n = 1'b1;
    @(posedge clock);
    #1;
    for (int a = 0; a < 8; a++) begin
      rf_rd_addr_a = 3'(a);
      #1;
      checks++;
      if (rd_a !== ((a == 0) ? 11'h000 : RV)) begin
        errors++;
        $display("FAIL post_reset_entry%0d got %h", a, rd_a);
      end
    end
    checks++;
    if (wrap !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_wrap got %b want 0", wrap);
    end
  endtask

  initial begin
    rf_reset_n   = 1'b0;
    rf_wr        = 1'b0;
    rf_op        = OP_LOAD;
    rf_wr_addr   = 3'd0;
    rf_wr_data   = 11'h000;
    rf_rd_addr_a = 3'd0;
    rf_rd_addr_b = 3'd0;
    test_reset();
    test_load();
    test_wrap();
    test_zero_oor();
    test_bypass();
    test_clr_hold();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_file.md
# register_file

Parametrised multi-entry register bank that generalises the single 11-bit write-enabled register used across the datapath. It holds NUM_REGS words of DATA_WIDTH bits, with one write port, two combinational read ports and in-place modify operations: load, increment, decrement and clear. It serves as the CPU's general-purpose and pointer register storage. A registered wrap flag reports increment/decrement overflow for stack-pointer and loop-counter use.

## Interface
- DATA_WIDTH, 11: word width in bits; minimum 2.
- NUM_REGS, 8: number of entries; minimum 2; need not be a power of two.
- ADDR_WIDTH, $clog2(NUM_REGS): address width (derived; do not override).
- RESET_VALUE, 0: value loaded into every entry on reset.
- ZERO_REG, 1: when 1, entry 0 always reads 0 and ignores all writes.
- BYPASS, 1: when 1, the read ports forward the value being written in the same cycle.

Ports:
- clock  in  1  rising-edge clock.
- rf_reset_n  in  1  reset, asynchronous and active-low.
- rf_wr  in  1  write/modify enable.
- rf_op  in  2  operation, rf_op_t: LOAD=00, INC=01, DEC=10, CLR=11.
- rf_wr_addr  in  ADDR_WIDTH  target entry.
- rf_wr_data  in  DATA_WIDTH  data for LOAD; ignored for the other operations.
- rf_rd_addr_a  in  ADDR_WIDTH  read port A address.
- rf_rd_addr_b  in  ADDR_WIDTH  read port B address.
- rf_rd_data_a  out  DATA_WIDTH  read port A data (combinational).
- rf_rd_data_b  out  DATA_WIDTH  read port B data (combinational).
- rf_wrap  out  1  registered single-cycle pulse on INC/DEC wrap-around.

## Operation
- Reset (rf_reset_n=0, asynchronous): every entry is set to RESET_VALUE and rf_wrap is set to 0. Entry 0 still reads 0 when ZERO_REG=1. Reset asserted mid-operation overrides any write in the same cycle.
- When rf_wr=1, the target entry takes its next value at the rising edge:
  - LOAD: next = rf_wr_data.
  - INC: next = cur+1, modulo 2^DATA_WIDTH.
  - DEC: next = cur-1, modulo 2^DATA_WIDTH.
  - CLR: next = 0.
- When rf_wr=0, all entries hold.
- Wrap flag:
  - rf_wrap=1 in the cycle after a committed INC of all-ones, or a committed DEC of 0.
  - Otherwise rf_wrap=0. It never stays high for two cycles unless a wrapping INC/DEC is committed back-to-back.
- Writes that are suppressed (ZERO_REG entry 0, or an out-of-range address) produce no state change and never raise rf_wrap.
- Reads:
  - Reads return the current entry value.
  - Address ≥ NUM_REGS reads 0.
  - With ZERO_REG=1, address 0 reads 0.
- Bypass:
  - Applies when BYPASS=1, rf_wr=1 and the read address equals rf_wr_addr of an effective write.
  - The read port returns the computed next value (the LOAD data or the INC/DEC/CLR result).
  - With BYPASS=0, the read port returns the old value.
- Both read ports may address the same entry, and each may match the write address; they are independent.

## Timing
- Write latency: one clock. The new value is visible on the read ports after the edge, or in the same cycle through bypass when BYPASS=1.
- Read ports are purely combinational from the address, the array and (with bypass) the write-port inputs.
- rf_wrap is asserted in the cycle after the edge that commits the wrapping operation.
- Reset assertion takes effect immediately. After release, the first write is accepted at the first rising edge with rf_reset_n=1.

## Structure
- Package register_file_pkg holds:
  - typedef enum logic [1:0] rf_op_t {RF_LOAD, RF_INC, RF_DEC, RF_CLR}.
  - Shared constants for the default widths (11-bit data, 8 entries).
- Sub-module rf_next_value (combinational) takes cur, rf_wr_data and rf_op. It outputs next and wrap, and is reused by both the write path and the bypass path.
- The storage array and the rf_wrap flop live in register_file, in one always_ff with asynchronous negedge reset.

## Test plan
Bench configuration: DATA_WIDTH=11, NUM_REGS=8, RESET_VALUE=0, unless stated otherwise.
- Reset, LOAD and read-back:
  - Reset with RESET_VALUE=11'h155 → all entries 1..7 read 11'h155 and entry 0 reads 0.
  - LOAD 11'h2A5 to entry 3 → port A at address 3 reads 11'h2A5 after the edge.
- Increment and decrement wrap:
  - LOAD 11'h7FF to entry 5, then INC → entry 5 = 0 and rf_wrap pulses high for exactly one cycle.
  - DEC on entry 5 → 11'h7FF and rf_wrap pulses high again.
- Zero register and out-of-range addresses:
  - LOAD 11'h123 to entry 0 → entry 0 still reads 0 and rf_wrap stays 0.
  - With NUM_REGS=6, LOAD to address 7 → no entry changes and the read at address 7 returns 0.
- Bypass:
  - Entry 2 = 11'h010; INC on entry 2 with rf_rd_addr_a=2 and rf_rd_addr_b=2 → both ports show 11'h011 in the same cycle.
  - With BYPASS=0, both ports show 11'h010 in that cycle.
- CLR and hold:
  - CLR on entry 4 holding 11'h3C3 → entry 4 = 0.
  - Subsequent cycles with rf_wr=0 and random rf_op → all entries unchanged.
- Reset mid-operation:
  - Assert rf_reset_n=0 mid-cycle while rf_wr=1 (LOAD 11'h0FF to entry 1) → all entries return to RESET_VALUE immediately, with no load after release.
  - rf_wrap=0 throughout.
